uart_rx_fifo: RTL

Receive-side buffer that sits directly downstream of the UART receiver. It takes each completed byte from the receiver's `rx_data`/`rx_ready` level handshake, acknowledges it with a one-cycle `rx_ready_clear` pulse, and stores it in a first-word-fall-through FIFO. Consumers drain the FIFO through a valid/ready port. Overruns are reported on a sticky `overflow` flag.

---
 rtl/uart_pkg.sv | 12 +
 rtl/sync_fifo.sv | 55 +++++
 rtl/uart_rx_fifo.sv | 84 ++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: data width and byte-capture FSM encoding.
// Used by both the RX and TX buffering paths.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_LOW = 1'b1
  } uart_cap_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock first-word-fall-through FIFO.
// Head word is a combinational read, gated to zero while empty.
module sync_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [W-1:0]      wdata,
  output logic [W-1:0]      rdata,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level
);

  localparam logic [ADDR_W:0] ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

  logic [W-1:0]      mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (level == '0);
  assign full    = (level == FULL);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push = push & (~full | do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + ONE;
        2'b01:   level <= level - ONE;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: captures each receiver byte once, acknowledges
// it with a one-cycle pulse, and queues it in an FWFT FIFO.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic [UART_DATA_W-1:0] rx_data,
  input  logic                   rx_ready,
  output logic                   rx_ready_clear,
  output logic [UART_DATA_W-1:0] out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ADDR_W:0]        level,
  output logic                   overflow,
  input  logic                   overflow_clear
);

  uart_cap_state_t state;
  uart_cap_state_t state_nxt;

  logic push;
  logic pop;
  logic drop;
  logic ack;
  logic full;
  logic empty;

  assign out_valid = ~empty;
  assign pop       = out_valid & out_ready;

  sync_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .W      (UART_DATA_W)
  ) u_fifo (
    .clk    (sys_clk),
    .rst_n  (sys_rst_n),
    .push   (push),
    .pop    (pop),
    .wdata  (rx_data),
    .rdata  (out_data),
    .full   (full),
    .empty  (empty),
    .level  (level)
  );

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    drop      = 1'b0;
    ack       = 1'b0;
    unique case (state)
      IDLE: begin
        if (rx_ready) begin
          ack       = 1'b1;
          state_nxt = WAIT_LOW;
          if (full && !pop) drop = 1'b1;
          else              push = 1'b1;
        end
      end
      WAIT_LOW: begin
        // Wait out the receiver's clear latency: one push per byte.
        if (!rx_ready) state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state          <= IDLE;
      rx_ready_clear <= 1'b0;
      overflow       <= 1'b0;
    end else begin
      state          <= state_nxt;
      rx_ready_clear <= ack;
      overflow       <= drop | (overflow & ~overflow_clear);
    end
  end

endmodule
